// File: rtl/prep_pkg.sv
// rtl/prep_pkg.sv - shared constants and FSM state type for the delta decoder
package prep_pkg;

    // Default sample / difference width.
    localparam int PREP_WIDTH = 16;

    // Two-bit state encodings; kept as plain constants so older code can match on them.
    localparam logic [1:0] ST_PRIME = 2'b01;
    localparam logic [1:0] ST_RUN   = 2'b10;

    typedef enum logic [1:0] {
        PRIME = ST_PRIME,
        RUN   = ST_RUN
    } prep_state_e;

endpackage

// File: rtl/stream_skid_buf.sv
// rtl/stream_skid_buf.sv - registered output stage backed by a 2-entry skid buffer
module stream_skid_buf #(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s_valid,
    input  logic [W-1:0] s_data,
    output logic         s_ready,
    output logic         m_valid,
    output logic [W-1:0] m_data,
    input  logic         m_ready
);

    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_data_q, out_data_d;
    logic [W-1:0] mem0_q, mem0_d;
    logic [W-1:0] mem1_q, mem1_d;
    logic [1:0]   count_q, count_d;
    logic         ready_q, ready_d;
    logic         push;
    logic         slot_free;
    logic         taken;

    // The output register refills from the oldest skid entry first; a new sample
    // goes straight to the output only when the skid is empty, so order is kept.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        mem0_d      = mem0_q;
        mem1_d      = mem1_q;
        count_d     = count_q;
        taken       = 1'b0;
        push        = s_valid & ready_q;
        slot_free   = ~out_valid_q | m_ready;

        if (slot_free) begin
            if (count_q != 2'd0) begin
                out_valid_d = 1'b1;
                out_data_d  = mem0_q;
                mem0_d      = mem1_q;
                count_d     = count_q - 2'd1;
            end else if (push) begin
                out_valid_d = 1'b1;
                out_data_d  = s_data;
                taken       = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end

        if (push && !taken) begin
            if (count_d == 2'd0) begin
                mem0_d = s_data;
            end else begin
                mem1_d = s_data;
            end
            count_d = count_d + 2'd1;
        end

        // Ready is registered so there is no combinational path from m_ready.
        ready_d = (count_d != 2'd2);
    end

    // State registers; reset empties the buffer and drops any pending output.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            mem0_q      <= '0;
            mem1_q      <= '0;
            count_q     <= 2'd0;
            ready_q     <= 1'b1;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            mem0_q      <= mem0_d;
            mem1_q      <= mem1_d;
            count_q     <= count_d;
            ready_q     <= ready_d;
        end
    end

    assign s_ready = ready_q;
    assign m_valid = out_valid_q;
    assign m_data  = out_data_q;

endmodule

// File: rtl/accum_delta_decoder.sv
// rtl/accum_delta_decoder.sv - recovers addends from an accumulated value stream
module accum_delta_decoder
    import prep_pkg::*;
#(
    parameter int WIDTH      = PREP_WIDTH,
    parameter int EMIT_FIRST = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             resync,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_borrow,
    output logic             primed
);

    prep_state_e      state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic             pend_q, pend_d;
    logic             in_fire;
    logic             do_prime;
    logic             emit;
    logic [WIDTH:0]   diff;
    logic [WIDTH:0]   out_payload;

    assign in_fire  = in_valid & in_ready;
    // A sample primes instead of emitting when not yet running or a resync is due.
    assign do_prime = (state_q == PRIME) | resync | pend_q;
    assign emit     = in_fire & ~do_prime;
    // Extra top bit of the subtraction is the borrow out of the MSB.
    assign diff     = {1'b0, in_data} - {1'b0, prev_q};

    // prev follows every accepted sample so ordering holds through the skid buffer.
    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        pend_d  = pend_q;
        if (in_fire) begin
            prev_d  = in_data;
            state_d = RUN;
            pend_d  = 1'b0;
        end else if (resync) begin
            pend_d  = 1'b1;
            state_d = PRIME;
        end
    end

    // FSM, prev and resync flag registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            if (EMIT_FIRST != 0) begin
                state_q <= RUN;
            end else begin
                state_q <= PRIME;
            end
            prev_q <= '0;
            pend_q <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            pend_q  <= pend_d;
        end
    end

    stream_skid_buf #(
        .W (WIDTH + 1)
    ) u_skid (
        .clk     (CLK),
        .rst     (RST),
        .s_valid (emit),
        .s_data  (diff),
        .s_ready (in_ready),
        .m_valid (out_valid),
        .m_data  (out_payload),
        .m_ready (out_ready)
    );

    assign out_data   = out_payload[WIDTH-1:0];
    assign out_borrow = out_payload[WIDTH];
    assign primed     = (state_q == RUN);

endmodule

// File: tb/tb_accum_delta_decoder.sv
// tb/tb_accum_delta_decoder.sv - scoreboard bench for accum_delta_decoder
module tb_accum_delta_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        resync, in_valid, in_ready, out_valid, out_ready, out_borrow, primed;
    logic [15:0] in_data, out_data;
    logic        resync0, in0_valid, in0_ready, out0_valid, out0_ready, out0_borrow, primed0;
    logic [15:0] in0_data, out0_data;

    always #5 clk = ~clk;

    accum_delta_decoder #(.WIDTH(16), .EMIT_FIRST(1)) dut (
        .CLK(clk), .RST(rst), .resync(resync), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_borrow(out_borrow), .primed(primed)
    );

    accum_delta_decoder #(.WIDTH(16), .EMIT_FIRST(0)) dut0 (
        .CLK(clk), .RST(rst), .resync(resync0), .in_valid(in0_valid), .in_ready(in0_ready),
        .in_data(in0_data), .out_valid(out0_valid), .out_ready(out0_ready), .out_data(out0_data),
        .out_borrow(out0_borrow), .primed(primed0)
    );

    typedef struct {
        logic [15:0] data;
        logic        borrow;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] dq[$];
    exp_t        e_mon, e_pop;
    bit          chain_mode = 1'b0;
    logic [15:0] m_prev;
    bit          m_run, m_pend;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Output scoreboard plus reference model of the decoder on the input side.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            m_prev = 16'h0000;
            m_run  = 1'b1;
            m_pend = 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                check_eq("sb_has_entry", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e_pop = sb.pop_front();
                    check_eq("sb_data", 32'(out_data), 32'(e_pop.data));
                    check_eq("sb_borrow", 32'(out_borrow), 32'(e_pop.borrow));
                end
                if (chain_mode) begin
                    check_eq("chain_has_d", 32'(dq.size() != 0), 1);
                    if (dq.size() != 0) check_eq("chain_d", 32'(out_data), 32'(dq.pop_front()));
                end
            end
            if (in_valid && in_ready) begin
                if (m_run && !m_pend && !resync) begin
                    e_mon.data   = in_data - m_prev;
                    e_mon.borrow = (in_data < m_prev);
                    sb.push_back(e_mon);
                end
                m_prev = in_data;
                m_run  = 1'b1;
                m_pend = 1'b0;
            end else if (resync) begin
                m_pend = 1'b1;
                m_run  = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] d);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check_eq("send_accept", 32'(ok), 1);
    endtask

    task automatic send0(input logic [15:0] d);
        bit ok = 1'b0;
        in0_valid = 1'b1;
        in0_data  = d;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (in0_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        in0_valid = 1'b0;
        check_eq("send0_accept", 32'(ok), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [15:0] vals [4];
    int          k, acc_cnt;
    bit          take;
    logic [15:0] acc, d_cur;

    initial begin
        rst = 1'b1; resync = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        resync0 = 1'b0; in0_valid = 1'b0; in0_data = '0; out0_ready = 1'b1;
        repeat (2) step();
        check_eq("rst_out_valid", 32'(out_valid), 0);
        check_eq("rst_out_data", 32'(out_data), 0);
        check_eq("rst_out_borrow", 32'(out_borrow), 0);
        check_eq("rst_in_ready", 32'(in_ready), 1);
        check_eq("rst_primed", 32'(primed), 1);
        check_eq("rst_primed0", 32'(primed0), 0);
        rst = 1'b0;
        step();

        // Basic stream, one cycle latency
        send(16'h0005);
        check_eq("t1_v0", 32'(out_valid), 1);
        check_eq("t1_d0", 32'(out_data), 'h5);
        send(16'h000C);
        check_eq("t1_d1", 32'(out_data), 'h7);
        send(16'h0010);
        check_eq("t1_d2", 32'(out_data), 'h4);

        // Wrap
        send(16'hFFF0);
        check_eq("t2_pre", 32'(out_data), 'hFFE0);
        send(16'h0010);
        check_eq("t2_wrap_d", 32'(out_data), 'h0020);
        check_eq("t2_wrap_b", 32'(out_borrow), 1);
        send(16'h0030);
        check_eq("t2_nowrap_d", 32'(out_data), 'h0020);
        check_eq("t2_nowrap_b", 32'(out_borrow), 0);
        step();

        // Back-pressure
        vals[0] = 16'h0100; vals[1] = 16'h0300; vals[2] = 16'h0700; vals[3] = 16'h0F00;
        out_ready = 1'b0; k = 0; acc_cnt = 0;
        in_valid = 1'b1; in_data = vals[0];
        repeat (4) begin
            @(negedge clk);
            take = in_ready;
            if (take) acc_cnt++;
            @(posedge clk);
            #1;
            if (take && k < 3) begin
                k++;
                in_data = vals[k];
            end
        end
        check_eq("t3_accepted", 32'(acc_cnt), 3);
        check_eq("t3_in_ready", 32'(in_ready), 0);
        check_eq("t3_held_v", 32'(out_valid), 1);
        check_eq("t3_held_d", 32'(out_data), 'h00D0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (5) step();
        check_eq("t3_drained", 32'(sb.size()), 0);

        // resync alone, then resync with a sample
        send(16'h0100);
        resync = 1'b1;
        step();
        resync = 1'b0;
        check_eq("t4_primed_lo", 32'(primed), 0);
        send(16'h9000);
        check_eq("t4_no_out", 32'(out_valid), 0);
        check_eq("t4_primed_hi", 32'(primed), 1);
        send(16'h9003);
        check_eq("t4_v", 32'(out_valid), 1);
        check_eq("t4_d", 32'(out_data), 'h0003);
        step();
        resync = 1'b1;
        send(16'hA000);
        resync = 1'b0;
        check_eq("t4b_no_out", 32'(out_valid), 0);
        send(16'hA005);
        check_eq("t4b_d", 32'(out_data), 'h0005);

        // EMIT_FIRST=0
        send0(16'h1234);
        check_eq("t5_no_out", 32'(out0_valid), 0);
        check_eq("t5_primed", 32'(primed0), 1);
        send0(16'h1236);
        check_eq("t5_v", 32'(out0_valid), 1);
        check_eq("t5_d", 32'(out0_data), 'h0002);
        step();

        // Reset with a full skid buffer
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 16'h4444;
        for (int i = 0; i < 10 && in_ready; i++) step();
        check_eq("t6_full", 32'(in_ready), 0);
        check_eq("t6_busy", 32'(out_valid), 1);
        rst = 1'b1;
        out_ready = 1'b1;
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        check_eq("t6_out_valid", 32'(out_valid), 0);
        check_eq("t6_in_ready", 32'(in_ready), 1);
        check_eq("t6_out_data", 32'(out_data), 0);
        send(16'h0007);
        check_eq("t6_prev_zero", 32'(out_data), 'h0007);
        step();

        // Accumulator chain with random handshakes
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        acc = 16'h0000;
        d_cur = 16'($urandom);
        chain_mode = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            in_data   = acc + d_cur;
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(3) != 0);
            @(negedge clk);
            if (in_valid && in_ready) begin
                acc = acc + d_cur;
                dq.push_back(d_cur);
                d_cur = 16'($urandom);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (6) step();
        check_eq("chain_sb_empty", 32'(sb.size()), 0);
        check_eq("chain_dq_empty", 32'(dq.size()), 0);
        chain_mode = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
